// File: rtl/mac_pkg.sv
// Shared widths, opcodes and types for the MAC issue sequencer.
// Response entries are packed {instr, protect, result}.
package mac_pkg;

    localparam int unsigned MacOpW   = 3;
    localparam int unsigned OperandW = 16;
    localparam int unsigned ResultW  = 32;
    localparam int unsigned ProtectW = 8;
    localparam int unsigned RspW     = MacOpW + ProtectW + ResultW;

    localparam logic [MacOpW-1:0] OpClr0 = 3'b000;
    localparam logic [MacOpW-1:0] OpClr1 = 3'b100;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } seq_state_e;

    typedef struct packed {
        logic              valid;
        logic [MacOpW-1:0] instr;
    } tag_t;

    typedef struct packed {
        logic [MacOpW-1:0]   instr;
        logic [ProtectW-1:0] protect;
        logic [ResultW-1:0]  result;
    } rsp_t;

    function automatic logic is_clr_op(input logic [MacOpW-1:0] op);
        return (op == OpClr0) || (op == OpClr1);
    endfunction

endpackage

// File: rtl/mac_rsp_fifo.sv
// Synchronous first-word-fall-through FIFO holding captured MAC responses.
// Push and pop may coincide in any fill state; pointers wrap modulo Depth.
module mac_rsp_fifo #(
    parameter int unsigned Width = 43,
    parameter int unsigned Depth = 4,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q;
    logic [PtrW-1:0]  rptr_q;
    logic [CntW-1:0]  cnt_q;
    logic [CntW-1:0]  cnt_d;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign pop_ok  = pop_i & ~empty_o;
    // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
    assign push_ok = push_i & (~full | pop_ok);
    assign rdata_o = mem_q[rptr_q];
    assign count_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wptr_q] <= wdata_i;
                wptr_q        <= wptr_q + PtrW'(1);
            end
            if (pop_ok) begin
                rptr_q <= rptr_q + PtrW'(1);
            end
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mac_issue_seq.sv
// Initiator side of the MAC operand interface: launches commands into the mac, tracks them
// through a tag pipe and returns captured results through a credit-limited response FIFO.
module mac_issue_seq
    import mac_pkg::*;
#(
    parameter int unsigned MacLat = 2,
    parameter int unsigned Depth  = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [MacOpW-1:0]   cmd_instr_i,
    input  logic [OperandW-1:0] cmd_a_i,
    input  logic [OperandW-1:0] cmd_b_i,
    output logic [MacOpW-1:0]   mac_instruction_o,
    output logic [OperandW-1:0] mac_multiplier_o,
    output logic [OperandW-1:0] mac_multiplicand_o,
    output logic                mac_stall_o,
    input  logic [ResultW-1:0]  mac_result_i,
    input  logic [ProtectW-1:0] mac_protect_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [ResultW-1:0]  rsp_result_o,
    output logic [ProtectW-1:0] rsp_protect_o,
    output logic [MacOpW-1:0]   rsp_instr_o,
    input  logic                flush_req_i,
    output logic                flush_done_o
);

    localparam int unsigned CntW = $clog2(Depth) + 1;
    localparam logic [CntW:0] DepthOcc = (CntW + 1)'(Depth);

    seq_state_e          state_q, state_d;
    logic                accept_en_q;
    logic                flush_done_q, flush_done_d;
    logic [CntW-1:0]     inflight_q, inflight_d;
    tag_t                tag_q [MacLat+1];
    logic [MacOpW-1:0]   mac_instr_q;
    logic [OperandW-1:0] mac_mult_q;
    logic [OperandW-1:0] mac_mcand_q;
    logic                mac_stall_q;

    logic                accept;
    logic                capture;
    logic                rsp_pop;
    logic                credit_ok;
    logic                drained;
    logic [CntW:0]       occupancy;
    logic [CntW-1:0]     fifo_count;
    logic                fifo_empty;
    rsp_t                push_rsp;
    rsp_t                head_rsp;

    assign rsp_valid_o = ~fifo_empty;
    assign rsp_pop     = rsp_valid_o & rsp_ready_i;
    assign capture     = tag_q[MacLat].valid;
    assign drained     = (inflight_q == '0) & fifo_empty;

    // A pop this cycle returns its credit immediately, which is what lets a full
    // pipeline plus one FIFO entry keep accepting one command per cycle.
    assign occupancy   = {1'b0, inflight_q} + {1'b0, fifo_count} - {{CntW{1'b0}}, rsp_pop};
    assign credit_ok   = occupancy < DepthOcc;
    assign cmd_ready_o = accept_en_q & credit_ok;
    assign accept      = cmd_valid_i & cmd_ready_o;

    always_comb begin
        push_rsp.instr   = tag_q[MacLat].instr;
        push_rsp.result  = mac_result_i;
        push_rsp.protect = mac_protect_i;
        if (is_clr_op(tag_q[MacLat].instr)) begin
            push_rsp.result  = '0;
            push_rsp.protect = '0;
        end
    end

    mac_rsp_fifo #(
        .Width (RspW),
        .Depth (Depth)
    ) u_rsp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (capture),
        .wdata_i (push_rsp),
        .pop_i   (rsp_pop),
        .rdata_o (head_rsp),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign rsp_result_o  = head_rsp.result;
    assign rsp_protect_o = head_rsp.protect;
    assign rsp_instr_o   = head_rsp.instr;

    always_comb begin
        inflight_d = inflight_q;
        case ({accept, capture})
            2'b10:   inflight_d = inflight_q + CntW'(1);
            2'b01:   inflight_d = inflight_q - CntW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        flush_done_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (flush_req_i) begin
                    state_d = StDrain;
                end else if (accept) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (flush_req_i) begin
                    state_d = StDrain;
                end else if (drained && !accept) begin
                    state_d = StIdle;
                end
            end
            StDrain: begin
                if (drained) begin
                    state_d      = StIdle;
                    flush_done_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            accept_en_q  <= 1'b0;
            flush_done_q <= 1'b0;
            inflight_q   <= '0;
            mac_instr_q  <= '0;
            mac_mult_q   <= '0;
            mac_mcand_q  <= '0;
            mac_stall_q  <= 1'b1;
            for (int i = 0; i <= int'(MacLat); i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            accept_en_q  <= (state_d != StDrain);
            flush_done_q <= flush_done_d;
            inflight_q   <= inflight_d;
            mac_stall_q  <= ~accept;
            if (accept) begin
                mac_instr_q <= cmd_instr_i;
                mac_mult_q  <= cmd_a_i;
                mac_mcand_q <= cmd_b_i;
            end
            // Stage 0 lines up with the launched operands; stage MacLat with the mac outputs.
            tag_q[0] <= '{valid: accept, instr: cmd_instr_i};
            for (int i = 1; i <= int'(MacLat); i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign mac_instruction_o  = mac_instr_q;
    assign mac_multiplier_o   = mac_mult_q;
    assign mac_multiplicand_o = mac_mcand_q;
    assign mac_stall_o        = mac_stall_q;
    assign flush_done_o       = flush_done_q;

endmodule
